// File: rtl/divider_32_if.sv
// Handshake and result bundle between the MIPS control unit and the multi-cycle divider.
// The master (control unit) issues requests, and the slave (divider) returns results and status.
interface divider_32_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/divider_32.sv
// Restoring shift/subtract divider for DIV/DIVU: one quotient bit per clock, quotient to LO, remainder to HI.
// The results, busy, done and div_by_zero are all registered, so there is no combinational path from the inputs.
module divider_32 #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   divider_32_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] p_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] divisor_r;
   logic [WIDTH-1:0] dividend_raw_r;
   logic             q_neg_r;
   logic             r_neg_r;
   logic             dz_r;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             busy_r;
   logic             done_r;
   logic             dz_out_r;

   logic [WIDTH:0]   p_shift_s;
   logic [WIDTH-1:0] diff_s;
   logic             ge_s;
   logic [WIDTH-1:0] p_next_s;
   logic [WIDTH-1:0] q_next_s;
   logic [WIDTH-1:0] q_res_s;
   logic [WIDTH-1:0] r_res_s;

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
      if (en && v[WIDTH-1]) begin
         return -v;
      end else begin
         return v;
      end
   endfunction

   // One restoring step plus the sign/divide-by-zero fix-up applied to that step's result
   always_comb begin
      p_shift_s = {p_r, q_r[WIDTH-1]};
      // Partial remainder needs WIDTH+1 bits, but a successful subtract always fits back into WIDTH
      diff_s    = p_shift_s[WIDTH-1:0] - divisor_r;
      ge_s      = (p_shift_s >= {1'b0, divisor_r});
      q_next_s  = {q_r[WIDTH-2:0], ge_s};
      if (ge_s) begin
         p_next_s = diff_s;
      end else begin
         p_next_s = p_shift_s[WIDTH-1:0];
      end
      if (dz_r) begin
         q_res_s = {WIDTH{1'b1}};
         r_res_s = dividend_raw_r;
      end else begin
         q_res_s = q_neg_r ? -q_next_s : q_next_s;
         r_res_s = r_neg_r ? -p_next_s : p_next_s;
      end
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= S_IDLE;
         cnt_r          <= CNT_ZERO;
         p_r            <= {WIDTH{1'b0}};
         q_r            <= {WIDTH{1'b0}};
         divisor_r      <= {WIDTH{1'b0}};
         dividend_raw_r <= {WIDTH{1'b0}};
         q_neg_r        <= 1'b0;
         r_neg_r        <= 1'b0;
         dz_r           <= 1'b0;
         quotient_r     <= {WIDTH{1'b0}};
         remainder_r    <= {WIDTH{1'b0}};
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         dz_out_r       <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  q_r            <= abs_val(bus.dividend, bus.is_signed);
                  divisor_r      <= abs_val(bus.divisor, bus.is_signed);
                  dividend_raw_r <= bus.dividend;
                  q_neg_r        <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                  r_neg_r        <= bus.is_signed & bus.dividend[WIDTH-1];
                  dz_r           <= (bus.divisor == {WIDTH{1'b0}});
                  p_r            <= {WIDTH{1'b0}};
                  cnt_r          <= CNT_INIT;
                  busy_r         <= 1'b1;
                  state_r        <= S_RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            S_RUN: begin
               p_r   <= p_next_s;
               q_r   <= q_next_s;
               cnt_r <= cnt_r - CNT_ONE;
               // Last step: results land together with done so the FIX cycle is the done cycle
               if (cnt_r == CNT_ZERO) begin
                  quotient_r  <= q_res_s;
                  remainder_r <= r_res_s;
                  dz_out_r    <= dz_r;
                  done_r      <= 1'b1;
                  state_r     <= S_FIX;
               end else begin
                  state_r <= S_RUN;
               end
            end
            S_FIX: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dz_out_r;
endmodule

// File: tb/tb_divider_32.sv
// Self-checking bench for divider_32: directed corner cases plus randomized operands checked
// against a plain-arithmetic reference model.
module tb_divider_32;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   divider_32_if #(.WIDTH(W)) bus ();
   divider_32 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Reference: the quotient truncates toward zero and the remainder follows the dividend's sign.
   // Divide by zero gives all ones and the raw dividend.
   function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Issue one request and follow it until done, with a bounded wait. This task only measures and makes no judgement.
   task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output int busy_n, output int changes);
      logic [31:0] q0, r0;
      @(negedge clk);
      bus.start = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
      q0 = bus.quotient; r0 = bus.remainder;
      @(negedge clk);
      bus.start = 1'b0; bus.is_signed = 1'($urandom); bus.dividend = $urandom; bus.divisor = $urandom;
      lat = 0; busy_n = 0; changes = 0; q = 32'd0; r = 32'd0; dz = 1'b0;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         if (bus.busy === 1'b1) busy_n++;
         if (bus.done === 1'b1) begin
            lat = n; q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
         end else begin
            if (bus.quotient !== q0 || bus.remainder !== r0) changes++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
      repeat (3) @(negedge clk);
      rst = 1'b0; bus.start = 1'b0;
      checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got %h exp 0", bus.quotient); end
      checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got %h exp 0", bus.remainder); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", bus.div_by_zero); end
   endtask

   task automatic test_unsigned();
      int lat, bn, ch; logic [31:0] q, r; logic dz;
      do_op(1'b0, 32'd100, 32'd7, lat, q, r, dz, bn, ch);
      checks++; if (lat != 33) begin errors++; $display("FAIL divu_latency got %0d exp 33", lat); end
      checks++; if (q !== 32'd14) begin errors++; $display("FAIL divu_q got %h exp %h", q, 32'd14); end
      checks++; if (r !== 32'd2) begin errors++; $display("FAIL divu_r got %h exp %h", r, 32'd2); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL divu_dz got %b exp 0", dz); end
      checks++; if (bn != 33) begin errors++; $display("FAIL divu_busy_cycles got %0d exp 33", bn); end
      checks++; if (ch != 0) begin errors++; $display("FAIL divu_outputs_held got %0d changes exp 0", ch); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL divu_after_done busy=%b done=%b exp 0 0", bus.busy, bus.done); end
   endtask

   task automatic test_signed();
      int lat, bn, ch; logic [31:0] q, r; logic dz;
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, q, r, dz, bn, ch);
      checks++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_2 got q=%h r=%h exp q=fffffffd r=ffffffff", q, r); end
      do_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, q, r, dz, bn, ch);
      checks++; if (q !== 32'hFFFF_FFFD || r !== 32'd1) begin errors++; $display("FAIL div_7_m2 got q=%h r=%h exp q=fffffffd r=00000001", q, r); end
      checks++; if (lat != 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
   endtask

   task automatic test_extremes();
      int lat, bn, ch; logic [31:0] q, r; logic dz;
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, dz, bn, ch);
      checks++; if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin errors++; $display("FAIL div_overflow got q=%h r=%h dz=%b exp q=80000000 r=0 dz=0", q, r, dz); end
      do_op(1'b0, 32'hFFFF_FFFF, 32'd1, lat, q, r, dz, bn, ch);
      checks++; if (q !== 32'hFFFF_FFFF || r !== 32'd0) begin errors++; $display("FAIL divu_max_1 got q=%h r=%h exp q=ffffffff r=0", q, r); end
      do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, dz, bn, ch);
      checks++; if (q !== 32'd0 || r !== 32'h8000_0000) begin errors++; $display("FAIL divu_big_divisor got q=%h r=%h exp q=0 r=80000000", q, r); end
   endtask

   task automatic test_div_by_zero();
      int lat, bn, ch; logic [31:0] q, r; logic dz;
      do_op(1'b0, 32'd5, 32'd0, lat, q, r, dz, bn, ch);
      checks++; if (q !== 32'hFFFF_FFFF || r !== 32'd5 || dz !== 1'b1) begin errors++; $display("FAIL dz_divu got q=%h r=%h dz=%b exp q=ffffffff r=5 dz=1", q, r, dz); end
      checks++; if (lat != 33) begin errors++; $display("FAIL dz_latency got %0d exp 33", lat); end
      @(negedge clk);
      checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_held got %b exp 1", bus.div_by_zero); end
      do_op(1'b1, 32'd9, 32'd3, lat, q, r, dz, bn, ch);
      checks++; if (q !== 32'd3 || r !== 32'd0 || dz !== 1'b0) begin errors++; $display("FAIL dz_clear got q=%h r=%h dz=%b exp q=3 r=0 dz=0", q, r, dz); end
      do_op(1'b1, 32'hFFFF_FFFB, 32'd0, lat, q, r, dz, bn, ch);
      checks++; if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFFB || dz !== 1'b1) begin errors++; $display("FAIL dz_div_neg got q=%h r=%h dz=%b exp q=ffffffff r=fffffffb dz=1", q, r, dz); end
   endtask

   task automatic test_random();
      int lat, bn, ch; logic [31:0] a, b, q, r, eq, er; logic dz, s;
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         a = $urandom;
         case (i % 5)
            0: b = $urandom;
            1: b = $urandom_range(1, 300);
            2: b = -$urandom_range(1, 300);
            3: b = 32'hFFFF_FFFF;
            default: b = (i % 10 == 4) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         endcase
         model(s, a, b, eq, er);
         do_op(s, a, b, lat, q, r, dz, bn, ch);
         checks++;
         if (q !== eq || r !== er || dz !== (b == 32'd0) || lat != 33) begin
            errors++;
            $display("FAIL random s=%b a=%h b=%h got q=%h r=%h dz=%b lat=%0d exp q=%h r=%h dz=%b lat=33",
                     s, a, b, q, r, dz, lat, eq, er, (b == 32'd0));
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat, bn, ch; logic [31:0] a, b, q, r, eq, er; logic dz;
      for (int i = 0; i < 3; i++) begin
         a = $urandom; b = $urandom_range(1, 1000);
         model(1'b1, a, b, eq, er);
         do_op(1'b1, a, b, lat, q, r, dz, bn, ch);
         checks++;
         if (q !== eq || r !== er || lat != 33) begin
            errors++; $display("FAIL back_to_back[%0d] got q=%h r=%h lat=%0d exp q=%h r=%h lat=33", i, q, r, lat, eq, er);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int done_n, done_at; logic [31:0] q, r;
      @(negedge clk);
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd99; bus.divisor = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      done_n = 0; done_at = 0; q = 32'd0; r = 32'd0;
      for (int n = 6; n <= 45; n++) begin
         if (bus.done === 1'b1) begin
            done_n++;
            if (done_at == 0) begin done_at = n; q = bus.quotient; r = bus.remainder; end
         end
         @(negedge clk);
      end
      checks++; if (done_n != 1 || done_at != 33) begin errors++; $display("FAIL ignore_start done_count=%0d at=%0d exp 1 at 33", done_n, done_at); end
      checks++; if (q !== 32'd10 || r !== 32'd0) begin errors++; $display("FAIL ignore_start_result got q=%h r=%h exp q=a r=0", q, r); end
   endtask

   task automatic test_reset_mid();
      int lat, bn, ch, done_n; logic [31:0] q, r; logic dz;
      @(negedge clk);
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 32'd0 || bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset busy=%b done=%b q=%h r=%h dz=%b exp all 0", bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
      end
      done_n = 0;
      for (int n = 0; n < 40; n++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) done_n++;
         @(negedge clk);
      end
      checks++; if (done_n != 0) begin errors++; $display("FAIL mid_reset_no_done got %0d active cycles exp 0", done_n); end
      do_op(1'b0, 32'd20, 32'd6, lat, q, r, dz, bn, ch);
      checks++; if (q !== 32'd3 || r !== 32'd2 || lat != 33) begin errors++; $display("FAIL after_reset got q=%h r=%h lat=%0d exp q=3 r=2 lat=33", q, r, lat); end
   endtask

   initial begin
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = 32'd0; bus.divisor = 32'd0;
      test_reset();
      test_unsigned();
      test_signed();
      test_extremes();
      test_div_by_zero();
      test_random();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
